poly_reduce_sched: RTL

- Sequencer that runs the pipelined Barrett coefficient reducer over every coefficient of a KYBER_K-polynomial vector held in a single-port-per-direction coefficient RAM.
- Streams read addresses into the RAM and pipes RAM data into the reducer. Tracks the reducer pipeline with a valid/address delay line and writes each reduced coefficient back in place.
- Sits between the NTT top-level control (start/done handshake) and the coefficient RAM plus reducer instance.

---
 rtl/poly_reduce_sched_if.sv | 43 ++++
 rtl/poly_reduce_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/poly_reduce_sched_if.sv
// Bus bundle between the reduce sequencer and its environment
// (NTT control handshake, coefficient RAM ports, Barrett reducer ports).
//
// Parameters:
//   ADDR_W   - coefficient RAM address width
//
// Signals (directions as seen from the sequencer, modport master):
//   start_i, abort_i       run request / cancel from NTT control
//   busy_o, done_o         run in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_o     RAM read port request
//   rd_data_i              RAM read data (signed coefficient)
//   red_in_o, red_out_i    reducer input / reducer output
//   wr_en_o, wr_addr_o,    RAM write port
//   wr_data_o
// Modport slave is the environment side (control, RAM and reducer).
interface poly_reduce_sched_if #(
  parameter int ADDR_W = 9
);
  logic              start_i;
  logic              abort_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [15:0]       rd_data_i;
  logic [15:0]       red_in_o;
  logic [11:0]       red_out_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [15:0]       wr_data_o;

  modport master (
    input  start_i, abort_i, rd_data_i, red_out_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, red_in_o,
           wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    output start_i, abort_i, rd_data_i, red_out_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, red_in_o,
           wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/poly_reduce_sched.sv
// Sequencer that streams every coefficient of a KYBER_K-polynomial vector
// from the coefficient RAM through the pipelined Barrett reducer and writes
// each result back in place.
//
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   bus      - poly_reduce_sched_if.master: start/abort/busy/done handshake,
//              RAM read/write ports and reducer in/out
//
// Optional feature (macro POLY_REDUCE_CSUB_EN): when defined, the write data
// gets a final conditional subtraction of KYBER_Q so stored coefficients are
// canonical in [0, KYBER_Q). Purely combinational; latency unchanged.
module poly_reduce_sched #(
  parameter int KYBER_K = 2,
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int ADDR_W  = 9,
  parameter int RAM_LAT = 1,
  parameter int RED_LAT = 4
) (
  input logic              clk,
  input logic              reset_n,
  poly_reduce_sched_if.master bus
);

  localparam int D     = RAM_LAT + RED_LAT;
  localparam int NCOEF = KYBER_K * KYBER_N;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCOEF - 1);

  if (D < 2 || (2 ** ADDR_W) < NCOEF || KYBER_Q < 1 || KYBER_Q > 4095) begin : g_cfg_check
    $error("poly_reduce_sched: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, done_q, rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              kill;
  logic              dl_tail_empty;

  // {valid, addr} delay line matching RAM + reducer latency
  logic [D-1:0]      dl_valid;
  logic [ADDR_W-1:0] dl_addr [D];

  // When stages 0..D-2 are empty the line will be empty after the next shift
  // (issue has stopped), so the DONE cycle lands right after the last write.
  assign dl_tail_empty = (dl_valid[D-2:0] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          kill    = 1'b1;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          kill    = 1'b1;
        end else if (dl_tail_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        kill    = bus.abort_i;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they change on
  // the same edge as the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      rd_en_q <= (state_d == S_ISSUE);
      if (state_q == S_IDLE && state_d == S_ISSUE) begin
        rd_addr_q <= '0;
      end else if (state_q == S_ISSUE && state_d == S_ISSUE) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_valid <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        dl_addr[i] <= '0;
      end
    end else begin
      dl_valid   <= kill ? '0 : {dl_valid[D-2:0], rd_en_q};
      dl_addr[0] <= rd_addr_q;
      for (int unsigned i = 1; i < D; i++) begin
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.red_in_o  = bus.rd_data_i;
  assign bus.wr_en_o   = dl_valid[D-1];
  assign bus.wr_addr_o = dl_addr[D-1];

`ifdef POLY_REDUCE_CSUB_EN
  localparam logic [11:0] Q12 = 12'(KYBER_Q);
  logic [11:0] csub;
  always_comb begin
    csub = (bus.red_out_i >= Q12) ? (bus.red_out_i - Q12) : bus.red_out_i;
  end
  assign bus.wr_data_o = {4'b0, csub};
`else
  assign bus.wr_data_o = {4'b0, bus.red_out_i};
`endif

endmodule
